timer_ctrl: RTL and testbench

Sequencing controller for the MM:SS down-counting timer datapath. It turns debounced front-panel buttons and the 1 Hz tick into the datapath's `load` and `ce` strobes, and detects expiry so the counter stops at 00:00 instead of wrapping. It also drives a timed alarm output and a state code for the display. It sits between the button debouncers, the 1 Hz divider and the timer counter chain.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_ctrl_if.sv | 27 ++
 rtl/timer_ctrl_edge_rise.sv | 18 +
 rtl/timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS timer sequencing controller:
// state encodings, BCD preset limits and the alarm counter width.
package timer_pkg;

  // State codes are also shown on the display's text mode, so they are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;
  localparam int         ALARM_CNT_W   = 8;

  // A minutes preset is usable when both nibbles are decimal and tens <= 5.
  function automatic logic bcd_preset_ok(input logic [7:0] preset);
    return (preset[3:0] <= BCD_UNITS_MAX) && (preset[7:4] <= BCD_TENS_MAX);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Front-panel / datapath bundle of the timer controller.
// master: the surroundings (buttons, divider, counter chain); slave: timer_ctrl.
interface timer_ctrl_if;
  import timer_pkg::*;

  logic       tick_1hz;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_load;
  logic [7:0] min_bcd;
  logic       zero;
  logic       load;
  logic       ce;
  logic       alarm;
  logic [2:0] state;
  logic       error;

  modport master (
    output tick_1hz, btn_start, btn_stop, btn_load, min_bcd, zero,
    input  load, ce, alarm, state, error
  );

  modport slave (
    input  tick_1hz, btn_start, btn_stop, btn_load, min_bcd, zero,
    output load, ce, alarm, state, error
  );
endinterface

// File: rtl/timer_ctrl_edge_rise.sv
// Single-bit rising-edge detector: the input is registered once and the
// edge is the combinational (d & ~d_q), so it acts in the cycle it appears.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the MM:SS down-counting timer.
// Turns button edges and the 1 Hz tick into registered load/ce strobes,
// stops the count at 00:00 and holds a timed alarm.
// Optional: TIMER_CTRL_BCD_CHECK_EN rejects non-BCD / tens>5 presets and
// raises error; without it loads are unconditional and error is 0.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input logic         clk,
  input logic         reset,
  timer_ctrl_if.slave bus
);
  localparam logic [ALARM_CNT_W-1:0] ALARM_LIMIT = ALARM_CNT_W'(ALARM_SECS);

  state_t                 state_q, state_d;
  logic                   load_q, load_d;
  logic                   ce_q, ce_d;
  logic                   alarm_q;
  logic                   err_q, err_d;
  logic [ALARM_CNT_W-1:0] cnt_q, cnt_d;
  logic [ALARM_CNT_W-1:0] cnt_inc;
  logic                   start_e, stop_e, load_e;
  logic                   preset_ok;
  logic                   load_ok;

  edge_rise u_start (.clk(clk), .reset(reset), .d(bus.btn_start), .rise(start_e));
  edge_rise u_stop  (.clk(clk), .reset(reset), .d(bus.btn_stop),  .rise(stop_e));
  edge_rise u_load  (.clk(clk), .reset(reset), .d(bus.btn_load),  .rise(load_e));

  assign preset_ok = bcd_preset_ok(bus.min_bcd);
  assign cnt_inc   = cnt_q + ALARM_CNT_W'(1);

`ifdef TIMER_CTRL_BCD_CHECK_EN
  assign load_ok = preset_ok;
`else
  logic unused_preset_ok;
  assign unused_preset_ok = preset_ok;
  assign load_ok          = 1'b1;
`endif

  // Next state and strobes; stop beats load beats start, a blocked load
  // still consumes the cycle so no ce goes out alongside it.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    ce_d    = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else if (load_e && load_ok) begin
          load_d  = 1'b1;
          state_d = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else if (load_e) begin
          load_d = load_ok;
        end else if (start_e && !bus.zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_e) begin
          state_d = ST_PAUSE;
        end else if (load_e) begin
          if (load_ok) begin
            load_d  = 1'b1;
            state_d = ST_LOADED;
          end
        end else if (bus.tick_1hz) begin
          if (bus.zero) begin
            state_d = ST_EXPIRED;
            cnt_d   = '0;
          end else begin
            ce_d = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else if (load_e) begin
          if (load_ok) begin
            load_d  = 1'b1;
            state_d = ST_LOADED;
          end
        end else if (start_e) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (stop_e || load_e || start_e) begin
          state_d = ST_IDLE;
        end else if (bus.tick_1hz) begin
          cnt_d = cnt_inc;
          if (cnt_inc == ALARM_LIMIT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TIMER_CTRL_BCD_CHECK_EN
    if (stop_e)                                  err_d = 1'b0;
    else if (load_e && state_q != ST_EXPIRED)    err_d = ~load_ok;
`else
    err_d = 1'b0;
`endif
  end

  // State, registered strobes, alarm and alarm counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      ce_q    <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      ce_q    <= ce_d;
      alarm_q <= (state_d == ST_EXPIRED);
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load  = load_q;
  assign bus.ce    = ce_q;
  assign bus.alarm = alarm_q;
  assign bus.state = state_q;
  assign bus.error = err_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: stimulus pushes the expected load/ce
// pulses (with the state they should accompany) into a queue, and a
// monitor pops and compares every time the DUT emits a pulse.
module tb_timer_ctrl;
  import timer_pkg::*;

  typedef struct packed {
    logic       load;
    logic       ce;
    logic [2:0] state;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e;

  timer_ctrl_if bus ();

  timer_ctrl #(.ALARM_SECS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every pulse the DUT issues must match the next expected entry.
  always @(negedge clk) begin
    if (reset && (bus.load || bus.ce)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual load=%0b ce=%0b state=%0d required no pulse",
                 bus.load, bus.ce, bus.state);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_load",  bus.load,  e.load);
        chk("pulse_ce",    bus.ce,    e.ce);
        chk("pulse_state", bus.state, e.state);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ld, input logic c, input logic [2:0] st);
    exp_t x;
    x.load = ld; x.ce = c; x.state = st;
    exp_q.push_back(x);
  endtask

  // 0 start, 1 stop, 2 load; the action is visible when the task returns.
  task automatic press(input int sel);
    cycle();
    case (sel)
      0: bus.btn_start = 1'b1;
      1: bus.btn_stop  = 1'b1;
      default: bus.btn_load = 1'b1;
    endcase
    cycle();
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_load  = 1'b0;
  endtask

  task automatic tick();
    cycle();
    bus.tick_1hz = 1'b1;
    cycle();
    bus.tick_1hz = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bus.tick_1hz  = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_load  = 1'b0;
    bus.min_bcd   = 8'h01;
    bus.zero      = 1'b0;
    repeat (3) cycle();
    chk("rst_state", bus.state, 0);
    chk("rst_load",  bus.load,  0);
    chk("rst_ce",    bus.ce,    0);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_error", bus.error, 0);
    reset = 1'b1;
    cycle();

    // Basic expiry
    press(0);
    chk("idle_start_ignored", bus.state, 0);
    push(1'b1, 1'b0, 3'd1);
    press(2);
    chk("load_to_loaded", bus.state, 1);
    bus.zero = 1'b1;
    press(0);
    chk("zero_guard", bus.state, 1);
    bus.zero = 1'b0;
    press(0);
    chk("start_to_run", bus.state, 2);
    for (int i = 0; i < 60; i++) begin
      push(1'b0, 1'b1, 3'd2);
      tick();
    end
    cycle();
    chk("ce_60_all_seen", 8'(exp_q.size()), 0);
    bus.zero = 1'b1;
    tick();
    chk("expire_state", bus.state, 4);
    chk("expire_alarm", bus.alarm, 1);
    chk("expire_no_ce", bus.ce, 0);

    // Alarm timeout (ALARM_SECS = 3)
    tick();
    tick();
    chk("alarm_hold_state", bus.state, 4);
    chk("alarm_hold_alarm", bus.alarm, 1);
    tick();
    chk("alarm_timeout_state", bus.state, 0);
    chk("alarm_timeout_alarm", bus.alarm, 0);

    // Pause and resume
    bus.zero = 1'b0;
    push(1'b1, 1'b0, 3'd1);
    press(2);
    press(0);
    chk("resume_run", bus.state, 2);
    press(1);
    chk("pause_state", bus.state, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("pause_hold", bus.state, 3);
    press(0);
    chk("pause_resume", bus.state, 2);
    push(1'b0, 1'b1, 3'd2);
    tick();
    chk("resume_ce", bus.ce, 1);
    press(1);
    press(1);
    chk("pause_stop_idle", bus.state, 0);

    // Coincident stop and tick in RUN
    push(1'b1, 1'b0, 3'd1);
    press(2);
    press(0);
    cycle();
    bus.btn_stop = 1'b1;
    bus.tick_1hz = 1'b1;
    cycle();
    bus.btn_stop = 1'b0;
    bus.tick_1hz = 1'b0;
    chk("stop_tick_state", bus.state, 3);
    chk("stop_tick_no_ce", bus.ce, 0);
    press(1);
    chk("stop_tick_idle", bus.state, 0);

    // Button edge leaves EXPIRED without starting
    push(1'b1, 1'b0, 3'd1);
    press(2);
    press(0);
    bus.zero = 1'b1;
    tick();
    chk("expire2_state", bus.state, 4);
    press(0);
    chk("expired_btn_idle", bus.state, 0);
    chk("expired_btn_alarm", bus.alarm, 0);
    bus.zero = 1'b0;

    // Preset check
    bus.min_bcd = 8'h6A;
`ifdef TIMER_CTRL_BCD_CHECK_EN
    press(2);
    chk("bad_preset_state", bus.state, 0);
    cycle();
    chk("bad_preset_error", bus.error, 1);
`else
    push(1'b1, 1'b0, 3'd1);
    press(2);
    chk("raw_preset_state", bus.state, 1);
    chk("raw_preset_error", bus.error, 0);
`endif
    bus.min_bcd = 8'h25;
    push(1'b1, 1'b0, 3'd1);
    press(2);
    chk("good_preset_state", bus.state, 1);
    chk("good_preset_error", bus.error, 0);
    press(1);
    chk("preset_stop_idle", bus.state, 0);

    // Async reset while a ce pulse is out
    push(1'b1, 1'b0, 3'd1);
    press(2);
    press(0);
    cycle();
    bus.tick_1hz = 1'b1;
    cycle();
    bus.tick_1hz = 1'b0;
    chk("pre_reset_ce", bus.ce, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_ce", bus.ce, 0);
    chk("async_reset_state", bus.state, 0);
    cycle();
    reset = 1'b1;
    press(0);
    chk("post_reset_start_ignored", bus.state, 0);

    repeat (3) cycle();
    chk("scoreboard_empty", 8'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
